// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment scan controller and the
// blocks that drive the BCD decoder.
package sseg_pkg;

    localparam int BCD_W = 4;

    // Anode and decimal-point lines are active-low; these are the "off" levels.
    localparam logic AN_OFF = 1'b1;
    localparam logic DP_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot counter plus digit index. The strobes announce what the next cycle
// will be, so the top can register its outputs in step with the counter.
module sseg_slot_timer
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int IDX_W       = $clog2(NUM_DIGITS),
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idx_next_o,
    output logic             slot_start_o,
    output logic             show_start_o,
    output logic             frame_wrap_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        slot_start_o = !clr_i && (cnt_q == CNT_LAST);
        show_start_o = !clr_i && (cnt_q == CNT_SHOW);
        frame_wrap_o = slot_start_o && (idx_q == IDX_LAST);
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        if (clr_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_start_o) begin
            cnt_d = '0;
            idx_d = frame_wrap_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o      = idx_q;
    assign idx_next_o = idx_d;

endmodule

// File: rtl/sseg_scan_controller.sv
// Time-multiplexes one BCD decoder across NUM_DIGITS common-anode digits with
// guard blanking, per-frame input snapshot and optional leading-zero suppression.
//
// state | meaning
// IDLE  | scan disabled, all anodes off, index parked at digit 0
// BLANK | slot guard time, decoder inputs updated, all anodes off
// SHOW  | anode of the current digit on (unless leading-zero blanked)
module sseg_scan_controller
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]       dp_mask_i,
    input  logic                        lz_blank_i,
    output logic [BCD_W-1:0]            bcd_count_o,
    output logic                        bcd_dp_o,
    output logic [NUM_DIGITS-1:0]       an_n_o,
    output logic [IDX_W-1:0]            digit_idx_o,
    output logic                        frame_tick_o
);

    state_e                      state_q, state_d;
    logic                        restart_q;
    logic [BCD_W*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]       snap_dp_q, snap_dp_d;
    logic                        snap_lz_q, snap_lz_d;
    logic [NUM_DIGITS-1:0]       an_n_q, an_n_d, an_lit, lz_hide;
    logic [BCD_W-1:0]            bcd_q, bcd_d;
    logic                        bcd_dp_q, bcd_dp_d;
    logic                        tick_q, tick_d;
    logic                        clr, start, load;
    logic                        slot_start, show_start, frame_wrap;
    logic [IDX_W-1:0]            idx, idx_next;

    // After reset or a disabled period the first enabled edge opens a fresh
    // frame at digit 0 instead of counting on from a stale slot.
    assign clr   = !en_i || restart_q;
    assign start = en_i && restart_q;
    assign load  = start || slot_start;

    sseg_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr),
        .idx_o        (idx),
        .idx_next_o   (idx_next),
        .slot_start_o (slot_start),
        .show_start_o (show_start),
        .frame_wrap_o (frame_wrap)
    );

    always_comb begin
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_lz_d     = snap_lz_q;
        if (start || frame_wrap) begin
            snap_digits_d = digits_i;
            snap_dp_d     = dp_mask_i;
            snap_lz_d     = lz_blank_i;
        end
    end

    // A digit is hidden only while every more-significant digit is also zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_hide  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (snap_digits_q[i*BCD_W +: BCD_W] == '0);
            lz_hide[i] = snap_lz_q && zero_run;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= BLANK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_i)           state_d = IDLE;
        else if (load)       state_d = BLANK;
        else if (show_start) state_d = SHOW;
    end

    always_comb begin
        an_lit   = lz_hide[idx] ? {NUM_DIGITS{AN_OFF}} : ~(NUM_DIGITS'(1) << idx);
        an_n_d   = {NUM_DIGITS{AN_OFF}};
        bcd_d    = bcd_q;
        bcd_dp_d = bcd_dp_q;
        tick_d   = frame_wrap;
        if (state_d == SHOW) an_n_d = (state_q == SHOW) ? an_n_q : an_lit;
        if (load) begin
            bcd_d    = snap_digits_d[idx_next*BCD_W +: BCD_W];
            bcd_dp_d = ~snap_dp_d[idx_next];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            restart_q     <= 1'b1;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
            an_n_q        <= {NUM_DIGITS{AN_OFF}};
            bcd_q         <= '0;
            bcd_dp_q      <= DP_OFF;
            tick_q        <= 1'b0;
        end else begin
            restart_q     <= !en_i;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
            an_n_q        <= an_n_d;
            bcd_q         <= bcd_d;
            bcd_dp_q      <= bcd_dp_d;
            tick_q        <= tick_d;
        end
    end

    assign bcd_count_o  = bcd_q;
    assign bcd_dp_o     = bcd_dp_q;
    assign an_n_o       = an_n_q;
    assign digit_idx_o  = idx;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller (4 digits, 8-cycle slots, 2 blank cycles).
module tb_sseg_scan_controller;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b1;
    logic [15:0] digits_i = 16'h1234;
    logic [3:0]  dp_mask_i = 4'b0000;
    logic        lz_blank_i = 1'b0;
    logic [3:0]  bcd_count_o;
    logic        bcd_dp_o;
    logic [3:0]  an_n_o;
    logic [1:0]  digit_idx_o;
    logic        frame_tick_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         idx;
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];

    sseg_scan_controller #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .digits_i     (digits_i),
        .dp_mask_i    (dp_mask_i),
        .lz_blank_i   (lz_blank_i),
        .bcd_count_o  (bcd_count_o),
        .bcd_dp_o     (bcd_dp_o),
        .an_n_o       (an_n_o),
        .digit_idx_o  (digit_idx_o),
        .frame_tick_o (frame_tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-slot results for one frame, derived from the display rules.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic lz,
                              input logic first);
        exp_t e;
        logic hidden;
        for (int i = 0; i < 4; i++) begin
            hidden = lz && (i >= 1) && ((d >> (4 * i)) == 16'h0);
            e.idx  = i;
            e.bcd  = d[4*i +: 4];
            e.dp   = ~dp[i];
            e.an   = hidden ? 4'b1111 : ~(4'b0001 << i);
            e.tick = (i == 0) && !first;
            sb_q.push_back(e);
        end
    endtask

    // Observes one whole slot; optionally changes digits_i at cycle chg_k.
    task automatic run_slot(input int chg_k, input logic [15:0] chg_digits);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >= 1");
            return;
        end
        e = sb_q.pop_front();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (k == chg_k) digits_i = chg_digits;
            chk($sformatf("d%0d_k%0d_idx", e.idx, k), 32'(digit_idx_o), 32'(e.idx));
            chk($sformatf("d%0d_k%0d_bcd", e.idx, k), 32'(bcd_count_o), 32'(e.bcd));
            chk($sformatf("d%0d_k%0d_dp", e.idx, k), 32'(bcd_dp_o), 32'(e.dp));
            chk($sformatf("d%0d_k%0d_an", e.idx, k), 32'(an_n_o),
                (k < 2) ? 32'hF : 32'(e.an));
            chk($sformatf("d%0d_k%0d_tick", e.idx, k), 32'(frame_tick_o),
                (k == 0) ? 32'(e.tick) : 32'h0);
            chk($sformatf("d%0d_k%0d_onehot", e.idx, k), 32'($countones(~an_n_o) <= 1), 32'h1);
        end
    endtask

    task automatic run_frame();
        for (int s = 0; s < 4; s++) run_slot(-1, 16'h0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an"}, 32'(an_n_o), 32'hF);
        chk({tag, "_bcd"}, 32'(bcd_count_o), 32'h0);
        chk({tag, "_dp"}, 32'(bcd_dp_o), 32'h1);
        chk({tag, "_idx"}, 32'(digit_idx_o), 32'h0);
        chk({tag, "_tick"}, 32'(frame_tick_o), 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk_reset_vals("reset");

        // basic scan, two frames; tick absent on start, present on wrap
        rst_i = 1'b0;
        push_frame(16'h1234, 4'b0000, 1'b0, 1'b1);
        run_frame();
        push_frame(16'h1234, 4'b0000, 1'b0, 1'b0);
        run_frame();

        // leading-zero suppression
        digits_i = 16'h0050;
        lz_blank_i = 1'b1;
        push_frame(16'h0050, 4'b0000, 1'b1, 1'b0);
        run_frame();
        digits_i = 16'h0000;
        push_frame(16'h0000, 4'b0000, 1'b1, 1'b0);
        run_frame();

        // decimal point on digit 2
        digits_i = 16'h1234;
        lz_blank_i = 1'b0;
        dp_mask_i = 4'b0100;
        push_frame(16'h1234, 4'b0100, 1'b0, 1'b0);
        run_frame();

        // input change inside digit 2's slot waits for the next frame
        dp_mask_i = 4'b0000;
        push_frame(16'h1234, 4'b0000, 1'b0, 1'b0);
        run_slot(-1, 16'h0);
        run_slot(-1, 16'h0);
        run_slot(3, 16'h5678);
        run_slot(-1, 16'h0);
        push_frame(16'h5678, 4'b0000, 1'b0, 1'b0);
        run_frame();

        // non-BCD codes pass through; nonzero top digit stops suppression
        digits_i = 16'hFA90;
        lz_blank_i = 1'b1;
        push_frame(16'hFA90, 4'b0000, 1'b1, 1'b0);
        run_frame();

        // enable dropped mid-SHOW
        digits_i = 16'h4321;
        lz_blank_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_en_drop_an", 32'(an_n_o), 32'hE);
        chk("pre_en_drop_bcd", 32'(bcd_count_o), 32'h1);
        en_i = 1'b0;
        @(negedge clk_i);
        chk("en_drop_an", 32'(an_n_o), 32'hF);
        chk("en_drop_idx", 32'(digit_idx_o), 32'h0);
        chk("en_drop_bcd_hold", 32'(bcd_count_o), 32'h1);
        chk("en_drop_dp_hold", 32'(bcd_dp_o), 32'h1);
        repeat (3) @(negedge clk_i);
        chk("idle_an", 32'(an_n_o), 32'hF);
        chk("idle_idx", 32'(digit_idx_o), 32'h0);
        chk("idle_tick", 32'(frame_tick_o), 32'h0);

        // re-enable starts a fresh frame without a tick
        digits_i = 16'h8765;
        en_i = 1'b1;
        push_frame(16'h8765, 4'b0000, 1'b0, 1'b1);
        run_frame();

        // asynchronous reset mid-slot
        digits_i = 16'h2468;
        repeat (4) @(negedge clk_i);
        chk("pre_rst_an", 32'(an_n_o), 32'hE);
        chk("pre_rst_bcd", 32'(bcd_count_o), 32'h8);
        #2 rst_i = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        digits_i = 16'h0305;
        lz_blank_i = 1'b1;
        push_frame(16'h0305, 4'b0000, 1'b1, 1'b1);
        run_frame();
        push_frame(16'h0305, 4'b0000, 1'b1, 1'b0);
        run_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
